pc_npc_sequencer: RTL and testbench
===================================

// Module: pc_npc_sequencer
// PURPOSE
//  Consumer end of the branch-target path. Holds the PA-RISC PC/nPC pair, advances the
//  fetch stream and accepts resolved branches (target TA = PC+8+4*disp). Applies delayed-branch
//  semantics and nullification of the delay slot. Feeds fetch; keeps a saturating taken-branch count.
// PARAMETERS
//  PC_W      8   PC/nPC/TA width in bits; arithmetic wraps mod 2**PC_W
//  RESET_PC  0   PC value loaded on reset; nPC resets to RESET_PC+4
//  CNT_W     16  width of the taken-branch counter
// PORTS
//  clk            in   1      single clock, all state on rising edge
//  reset          in   1      synchronous, active-high
//  le             in   1      advance enable; 0 = stall, all state held
//  branch_valid   in   1      instruction at pc is a branch, resolved this cycle
//  branch_cond    in   1      1 = conditional branch, 0 = unconditional
//  branch_taken   in   1      branch condition outcome (ignored when branch_cond=0; treated as 1)
//  n_bit          in   1      nullify bit of the branch instruction
//  disp_neg       in   1      displacement sign (1 = backward branch)
//  ta             in   PC_W   branch target address; ta[1:0] ignored, forced 00
//  pc             out  PC_W   address of instruction currently issued
//  npc            out  PC_W   address of next instruction
//  fetch_valid    out  1      pc holds a real issued instruction
//  nullify_slot   out  1      instruction at pc is nullified (do not commit)
//  redirect       out  1      1-cycle pulse: npc was loaded from ta
//  taken_count    out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//  Reset (reset=1 at edge, overrides le): pc=RESET_PC, npc=RESET_PC+4, state=FILL,
//   fetch_valid=0, nullify_slot=0, redirect=0, taken_count=0. Reset mid-stall or mid-slot aborts all.
//  le=0: pc, npc, state, counter held; branch_* ignored; redirect forced 0 next cycle.
//  Advance (le=1): pc<=npc; npc<=take ? {ta[PC_W-1:2],2'b00} : npc+4 (mod 2**PC_W).
//   take = branch_valid & state!=NULL & (~branch_cond | branch_taken).
//  Latency: branch sampled on edge E -> delay slot at pc after E -> target at pc after E+1.
//  Nullify decision (only when branch accepted):
//   conditional: null = n_bit & ((branch_taken & ~disp_neg) | (~branch_taken & disp_neg))
//   unconditional: null = n_bit
//  FSM (state advances only when le=1):
//   FILL : fetch_valid=0, branch inputs ignored -> RUN
//   RUN  : normal issue -> NULL if accepted branch & null; SLOT if take & ~null; else RUN
//   SLOT : delay slot of taken branch, executes; branch here is honored (npc<=ta) -> same rules as RUN
//   NULL : slot nullified, nullify_slot=1; branch_valid ignored (no redirect, no count) -> RUN
//  Outputs are registered: fetch_valid=(state!=FILL), nullify_slot=(state==NULL),
//   redirect=1 for exactly the cycle after an edge with take=1 and le=1.
//  taken_count increments on each take edge; holds at 2**CNT_W-1 (no wrap).
//  Wrap: npc=8'hFC +4 -> 8'h00; ta wraps likewise (caller already truncated).
//  Simultaneous reset+le+branch: reset wins, no count, no redirect.
// STRUCTURE
//  Shared package pa_risc_pkg: PC_W, INSN_BYTES=4, RESET_PC, seq_state_t {FILL,RUN,SLOT,NULL}.
//  One sub-module: npc_incr (PC_W-bit +INSN_BYTES adder, combinational), the +4 counterpart
//   of the +8 return-address adder. FSM, PC/nPC regs and counter live in the top.
// TESTING
//  1 reset, le=1, no branches 4 cycles -> fetch_valid 0,1,1,1; pc 00,04,08,0C; npc 04,08,0C,10
//  2 pc=08, uncond branch ta=40 n=0 -> pc 0C (slot, nullify_slot=0, redirect=1), then pc 40, count=1
//  3 pc=08, cond taken fwd n=1 ta=40 -> pc 0C nullify_slot=1, pc 40; cond not-taken bwd n=1 -> slot nullified, pc 10
//  4 branch while in NULL -> ignored, no redirect, count unchanged; branch in SLOT ta=80 -> pc goes slot, 40, 80
//  5 le=0 for 3 cycles with branch_valid=1 -> pc/npc/count frozen; npc FC advance -> 00 wrap
//  6 reset asserted in SLOT with branch_valid=1 -> pc=00 npc=04 FILL, count=0; CNT_W=2, 5 taken -> count stays 3

Source files
------------

// File: rtl/pc_npc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pa_risc_pkg
// Brief   : Shared PA-RISC sequencer constants and state encoding.
// Revision: 1.0
// ============================================================================
package pa_risc_pkg;

  localparam int PC_W       = 8;
  localparam int INSN_BYTES = 4;
  localparam int RESET_PC   = 0;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_SLOT = 2'd2,
    S_NULL = 2'd3
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_npc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_npc_sequencer_if
// Brief   : Branch-resolution inputs and fetch-side outputs of the sequencer.
// Revision: 1.0
// ============================================================================
interface pc_npc_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             le;
  logic             branch_valid;
  logic             branch_cond;
  logic             branch_taken;
  logic             n_bit;
  logic             disp_neg;
  logic [PC_W-1:0]  ta;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  npc;
  logic             fetch_valid;
  logic             nullify_slot;
  logic             redirect;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output le, branch_valid, branch_cond, branch_taken, n_bit, disp_neg, ta,
    input  pc, npc, fetch_valid, nullify_slot, redirect, taken_count
  );

  modport slave (
    input  le, branch_valid, branch_cond, branch_taken, n_bit, disp_neg, ta,
    output pc, npc, fetch_valid, nullify_slot, redirect, taken_count
  );
endinterface
`default_nettype wire

// File: rtl/pc_npc_sequencer_npc_incr.sv
`default_nettype none
// ============================================================================
// Module  : npc_incr
// Brief   : Sequential next-instruction adder, wraps modulo 2**PC_W.
// Revision: 1.0
// ============================================================================
module npc_incr
  import pa_risc_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  wire logic [PC_W-1:0] i_addr,
  output wire logic [PC_W-1:0] o_addr
);
  assign o_addr = i_addr + PC_W'(INSN_BYTES);
endmodule
`default_nettype wire

// File: rtl/pc_npc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_npc_sequencer
// Brief   : PC/nPC pair with delayed-branch, delay-slot nullify, taken counter.
// Revision: 1.0
// ============================================================================
module pc_npc_sequencer #(
  parameter int               PC_W     = pa_risc_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(pa_risc_pkg::RESET_PC),
  parameter int               CNT_W    = 16
) (
  input wire logic          clk,
  input wire logic          reset,
  pc_npc_sequencer_if.slave bus
);
  import pa_risc_pkg::*;

  localparam logic [PC_W-1:0]  RESET_NPC = RESET_PC + PC_W'(INSN_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  npc_q, npc_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PC_W-1:0]  w_npc_plus4;
  logic [PC_W-1:0]  w_target;
  logic             w_accept;
  logic             w_take;
  logic             w_null;

  npc_incr #(.PC_W(PC_W)) u_npc_incr (
    .i_addr (npc_q),
    .o_addr (w_npc_plus4)
  );

  assign w_target = {bus.ta[PC_W-1:2], 2'b00};

  // Branches only count when a real, non-nullified instruction sits at pc.
  assign w_accept = bus.branch_valid && (state_q == S_RUN || state_q == S_SLOT);
  assign w_take   = w_accept && (!bus.branch_cond || bus.branch_taken);
  assign w_null   = bus.n_bit && (!bus.branch_cond ||
                                  (bus.branch_taken != bus.disp_neg));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    count_d    = count_q;
    redirect_d = 1'b0;
    if (bus.le) begin
      pc_d       = npc_q;
      npc_d      = w_take ? w_target : w_npc_plus4;
      redirect_d = w_take;
      if (w_take && count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
      case (state_q)
        S_FILL: state_d = S_RUN;
        S_NULL: state_d = S_RUN;
        default: begin
          if (w_accept && w_null) begin
            state_d = S_NULL;
          end else if (w_take) begin
            state_d = S_SLOT;
          end else begin
            state_d = S_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FILL;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_NPC;
      redirect_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      redirect_q <= redirect_d;
      count_q    <= count_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.npc          = npc_q;
  assign bus.fetch_valid  = (state_q != S_FILL);
  assign bus.nullify_slot = (state_q == S_NULL);
  assign bus.redirect     = redirect_q;
  assign bus.taken_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_npc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_npc_sequencer
// Brief   : Directed-vector scoreboard bench for pc_npc_sequencer (CNT_W=2).
// Revision: 1.0
// ============================================================================
module tb_pc_npc_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pc_npc_sequencer_if #(.PC_W(8), .CNT_W(2)) bus ();

  pc_npc_sequencer #(.PC_W(8), .RESET_PC(8'h00), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] npc;
    logic       fv;
    logic       ns;
    logic       rd;
    logic [1:0] cnt;
    string      nm;
  } exp_t;

  exp_t sb[$];

  // Each queued entry is the state expected just after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.npc !== e.npc || bus.fetch_valid !== e.fv ||
            bus.nullify_slot !== e.ns || bus.redirect !== e.rd ||
            bus.taken_count !== e.cnt) begin
          errors++;
          $display("FAIL %s: got pc=%h npc=%h fv=%b ns=%b rd=%b cnt=%0d, want pc=%h npc=%h fv=%b ns=%b rd=%b cnt=%0d",
                   e.nm, bus.pc, bus.npc, bus.fetch_valid, bus.nullify_slot, bus.redirect,
                   bus.taken_count, e.pc, e.npc, e.fv, e.ns, e.rd, e.cnt);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic l, input logic bv, input logic bc,
                     input logic bt, input logic nb, input logic dn, input logic [7:0] t,
                     input logic [7:0] epc, input logic [7:0] enpc, input logic efv,
                     input logic ens, input logic erd, input logic [1:0] ecnt,
                     input string nm);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.le           = l;
    bus.branch_valid = bv;
    bus.branch_cond  = bc;
    bus.branch_taken = bt;
    bus.n_bit        = nb;
    bus.disp_neg     = dn;
    bus.ta           = t;
    e.pc = epc; e.npc = enpc; e.fv = efv; e.ns = ens; e.rd = erd; e.cnt = ecnt; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    cyc(1, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h04, 0, 0, 0, 2'd0, nm);
  endtask

  task automatic adv(input logic [7:0] epc, input logic [7:0] enpc, input logic ens,
                     input logic [1:0] ecnt, input string nm);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, epc, enpc, 1, ens, 0, ecnt, nm);
  endtask

  task automatic to_pc08();
    adv(8'h04, 8'h08, 0, 2'd0, "fill_04");
    adv(8'h08, 8'h0C, 0, 2'd0, "run_08");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.le = 1'b0; bus.branch_valid = 1'b0; bus.branch_cond = 1'b0;
    bus.branch_taken = 1'b0; bus.n_bit = 1'b0; bus.disp_neg = 1'b0; bus.ta = 8'h00;

    // Sequential fetch out of reset.
    do_reset("reset_state");
    adv(8'h04, 8'h08, 0, 2'd0, "seq_04");
    adv(8'h08, 8'h0C, 0, 2'd0, "seq_08");
    adv(8'h0C, 8'h10, 0, 2'd0, "seq_0c");

    // Unconditional, no nullify: slot executes, then target.
    do_reset("reset_t2");
    to_pc08();
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h40, 8'h0C, 8'h40, 1, 0, 1, 2'd1, "uncond_slot");
    adv(8'h40, 8'h44, 0, 2'd1, "uncond_target");

    // Conditional taken forward with n: slot nullified.
    do_reset("reset_t3a");
    to_pc08();
    cyc(0, 1, 1, 1, 1, 1, 0, 8'h40, 8'h0C, 8'h40, 1, 1, 1, 2'd1, "cond_fwd_null");
    adv(8'h40, 8'h44, 0, 2'd1, "cond_fwd_target");
    // Conditional not-taken backward with n: slot nullified, falls through.
    do_reset("reset_t3b");
    to_pc08();
    cyc(0, 1, 1, 1, 0, 1, 1, 8'h00, 8'h0C, 8'h10, 1, 1, 0, 2'd0, "cond_bwd_null");
    adv(8'h10, 8'h14, 0, 2'd0, "cond_bwd_fall");

    // Branch in NULL ignored; branch in SLOT honoured; counter saturates at 3.
    do_reset("reset_t4");
    to_pc08();
    cyc(0, 1, 1, 0, 0, 1, 0, 8'h40, 8'h0C, 8'h40, 1, 1, 1, 2'd1, "uncond_null");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h80, 8'h40, 8'h44, 1, 0, 0, 2'd1, "br_in_null_ign");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h60, 8'h44, 8'h60, 1, 0, 1, 2'd2, "br_run_60");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h80, 8'h60, 8'h80, 1, 0, 1, 2'd3, "br_in_slot_80");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'hA0, 8'h80, 8'hA0, 1, 0, 1, 2'd3, "sat_4th");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'hC0, 8'hA0, 8'hC0, 1, 0, 1, 2'd3, "sat_5th");
    adv(8'hC0, 8'hC4, 0, 2'd3, "sat_target");

    // Stall with branch_valid asserted, then wrap past FC.
    do_reset("reset_t5");
    to_pc08();
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h40, 8'h08, 8'h0C, 1, 0, 0, 2'd0, "stall_1");
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h40, 8'h08, 8'h0C, 1, 0, 0, 2'd0, "stall_2");
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h40, 8'h08, 8'h0C, 1, 0, 0, 2'd0, "stall_3");
    adv(8'h0C, 8'h10, 0, 2'd0, "post_stall");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'hF9, 8'h10, 8'hF8, 1, 0, 1, 2'd1, "ta_low_forced");
    adv(8'hF8, 8'hFC, 0, 2'd1, "pre_wrap");
    adv(8'hFC, 8'h00, 0, 2'd1, "npc_wrap");
    adv(8'h00, 8'h04, 0, 2'd1, "pc_wrap");

    // Reset in SLOT with a branch present; branch during FILL ignored.
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h20, 8'h04, 8'h20, 1, 0, 1, 2'd2, "enter_slot");
    cyc(1, 1, 1, 0, 0, 0, 0, 8'h40, 8'h00, 8'h04, 0, 0, 0, 2'd0, "reset_in_slot");
    cyc(0, 1, 1, 0, 0, 0, 0, 8'h40, 8'h04, 8'h08, 1, 0, 0, 2'd0, "br_in_fill_ign");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
